// File: rtl/sum_pipe.sv
// Pipelined adder/subtractor: the carry chain is cut into STAGES equal segments,
// one register slice per segment, with a valid/ready handshake and full backpressure.

module sum_pipe_stage #(
    parameter int WIDTH = 4,
    parameter int SEG   = 2,
    parameter int K     = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic             v_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [WIDTH-1:0] s_i,
    input  logic             c_i,
    output logic             v_o,
    output logic [WIDTH-1:0] a_o,
    output logic [WIDTH-1:0] b_o,
    output logic [WIDTH-1:0] s_o,
    output logic             c_o
);
    logic [SEG:0]       seg_sum;
    logic [WIDTH-1:0]   s_d;
    logic               c_d;
    logic               v_q, c_q;
    logic [WIDTH-1:0]   a_q, b_q, s_q;

    // Only slice K is added here; lower slices are already final, upper ones ride along.
    always_comb begin
        seg_sum = {1'b0, a_i[K*SEG +: SEG]} + {1'b0, b_i[K*SEG +: SEG]} + {{SEG{1'b0}}, c_i};
        s_d = s_i;
        s_d[K*SEG +: SEG] = seg_sum[SEG-1:0];
        c_d = seg_sum[SEG];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v_q <= 1'b0;
            a_q <= '0;
            b_q <= '0;
            s_q <= '0;
            c_q <= 1'b0;
        end else if (en_i) begin
            v_q <= v_i;
            a_q <= a_i;
            b_q <= b_i;
            s_q <= s_d;
            c_q <= c_d;
        end
    end

    assign v_o = v_q;
    assign a_o = a_q;
    assign b_o = b_q;
    assign s_o = s_q;
    assign c_o = c_q;
endmodule

module sum_pipe #(
    parameter int WIDTH  = 4,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] data_a,
    input  logic [WIDTH-1:0] data_b,
    input  logic             c_in,
    input  logic             op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out
);
    localparam int SEG = WIDTH / STAGES;

    logic [STAGES:0]            vld_pipe;
    logic [STAGES:0]            c_p;
    logic [STAGES:0][WIDTH-1:0] a_p, b_p, s_p;
    logic                       stall;
    logic                       unused_bits;

    // The whole pipe freezes as one when the head result is not taken.
    assign stall    = vld_pipe[STAGES] && !out_ready;
    assign in_ready = !stall;

    // Subtract is a + ~b + 1; c_in only matters for add.
    assign vld_pipe[0] = in_valid;
    assign a_p[0]      = data_a;
    assign b_p[0]      = op ? ~data_b : data_b;
    assign c_p[0]      = op | c_in;
    assign s_p[0]      = '0;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        sum_pipe_stage #(.WIDTH(WIDTH), .SEG(SEG), .K(k)) u_stage (
            .clk  (clk),
            .rst  (rst),
            .en_i (!stall),
            .v_i  (vld_pipe[k]),
            .a_i  (a_p[k]),
            .b_i  (b_p[k]),
            .s_i  (s_p[k]),
            .c_i  (c_p[k]),
            .v_o  (vld_pipe[k+1]),
            .a_o  (a_p[k+1]),
            .b_o  (b_p[k+1]),
            .s_o  (s_p[k+1]),
            .c_o  (c_p[k+1])
        );
    end

    assign out_valid   = vld_pipe[STAGES];
    assign sum         = s_p[STAGES];
    assign c_out       = c_p[STAGES];
    assign unused_bits = ^{a_p[STAGES], b_p[STAGES]};
endmodule

// File: tb/tb_sum_pipe.sv
// Bench for sum_pipe: three configurations (4/2, 8/4, 4/1) share stimulus; each has
// its own scoreboard fed on accept and drained on consume.

module tb_sum_pipe;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0;
    logic out_ready = 1'b1;
    logic [7:0] a = '0, b = '0;
    logic cin = 1'b0, op = 1'b0;
    logic use_tbl = 1'b0;
    logic [4:0] tbl_exp = '0;

    logic rdy2, ov2, c2, rdy4, ov4, c4, rdy1, ov1, c1;
    logic [3:0] s2, s1;
    logic [7:0] s4;

    int n_checks = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    sum_pipe #(.WIDTH(4), .STAGES(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy2),
        .data_a(a[3:0]), .data_b(b[3:0]), .c_in(cin), .op(op),
        .out_valid(ov2), .out_ready(out_ready), .sum(s2), .c_out(c2));
    sum_pipe #(.WIDTH(8), .STAGES(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy4),
        .data_a(a), .data_b(b), .c_in(cin), .op(op),
        .out_valid(ov4), .out_ready(out_ready), .sum(s4), .c_out(c4));
    sum_pipe #(.WIDTH(4), .STAGES(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1),
        .data_a(a[3:0]), .data_b(b[3:0]), .c_in(cin), .op(op),
        .out_valid(ov1), .out_ready(out_ready), .sum(s1), .c_out(c1));

    typedef struct {
        logic [8:0] exp;
        logic [7:0] a, b;
        logic       cin, op;
    } sb_t;
    sb_t q2[$], q4[$], q1[$];

    typedef struct {
        logic [3:0] a, b;
        logic       cin, op;
        logic [4:0] exp;
    } vec_t;
    vec_t tbl[9];

    // Reference: plain integer add, or difference plus an a>=b no-borrow flag.
    function automatic logic [8:0] model(logic [7:0] ma, logic [7:0] mb, logic mc, logic mo, int w);
        int unsigned mask, ai, bi, r;
        logic c;
        mask = (32'd1 << w) - 32'd1;
        ai = 32'(ma) & mask;
        bi = 32'(mb) & mask;
        if (!mo) begin
            r = ai + bi + 32'(mc);
            c = ((r >> w) & 32'd1) != 0;
        end else begin
            c = ai >= bi;
            r = ai - bi;
        end
        model = {c, 8'(r & mask)};
    endfunction

    function automatic sb_t mk(logic [8:0] e);
        sb_t s;
        s.exp = e; s.a = a; s.b = b; s.cin = cin; s.op = op;
        return s;
    endfunction

    task automatic chk(string name, logic [8:0] act, logic [8:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, want %h", name, act, exp);
    endtask

    task automatic cmp(string tag, sb_t e, logic [8:0] act);
        n_checks++;
        if (act === e.exp) n_pass++;
        else $display("FAIL %s result a=%h b=%h cin=%b op=%b: got %h, want %h",
                      tag, e.a, e.b, e.cin, e.op, act, e.exp);
    endtask

    task automatic spurious(string tag);
        n_checks++;
        $display("FAIL %s unexpected out_valid: got 1, want 0 (no pending result)", tag);
    endtask

    // Sampled mid-cycle: what is seen here is what the next rising edge acts on.
    always @(negedge clk) begin
        if (rst) begin
            q2.delete(); q4.delete(); q1.delete();
        end else begin
            if (ov2 && out_ready) begin
                if (q2.size() == 0) spurious("d2"); else cmp("d2", q2.pop_front(), {c2, 4'h0, s2});
            end
            if (ov4 && out_ready) begin
                if (q4.size() == 0) spurious("d4"); else cmp("d4", q4.pop_front(), {c4, s4});
            end
            if (ov1 && out_ready) begin
                if (q1.size() == 0) spurious("d1"); else cmp("d1", q1.pop_front(), {c1, 4'h0, s1});
            end
            if (in_valid && rdy2)
                q2.push_back(mk(use_tbl ? {tbl_exp[4], 4'h0, tbl_exp[3:0]} : model(a, b, cin, op, 4)));
            if (in_valid && rdy4) q4.push_back(mk(model(a, b, cin, op, 8)));
            if (in_valid && rdy1) q1.push_back(mk(model(a, b, cin, op, 4)));
        end
    end

    // Entered just after a rising edge; returns just after the edge that accepted.
    task automatic send(vec_t v);
        bit ok;
        ok = 0;
        a = {4'h0, v.a}; b = {4'h0, v.b}; cin = v.cin; op = v.op;
        tbl_exp = v.exp; use_tbl = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (rdy2) ok = 1;
            @(posedge clk); #1;
        end
        if (!ok) begin
            n_checks++;
            $display("FAIL send timeout: in_ready stayed 0, want 1 within 20 cycles");
        end
    endtask

    task automatic drain(int n);
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int adds[5];
        int cyc;
        logic [8:0] held;
        adds = '{0, 1, 2, 5, 6};
        tbl[0] = '{4'b1010, 4'b0111, 1'b0, 1'b0, 5'b1_0001};
        tbl[1] = '{4'b0111, 4'b0001, 1'b1, 1'b0, 5'b0_1001};
        tbl[2] = '{4'b1111, 4'b1111, 1'b1, 1'b0, 5'b1_1111};
        tbl[3] = '{4'b0101, 4'b0011, 1'b0, 1'b1, 5'b1_0010};
        tbl[4] = '{4'b0011, 4'b0101, 1'b0, 1'b1, 5'b0_1110};
        tbl[5] = '{4'b0000, 4'b0000, 1'b0, 1'b0, 5'b0_0000};
        tbl[6] = '{4'b1000, 4'b1000, 1'b0, 1'b0, 5'b1_0000};
        tbl[7] = '{4'b0110, 4'b0110, 1'b0, 1'b1, 5'b1_0000};
        tbl[8] = '{4'b0000, 4'b0001, 1'b1, 1'b1, 5'b0_1111};

        // reset state
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset sum", {5'h0, s2}, 9'h0);
        chk("reset c_out", {8'h0, c2}, 9'h0);
        chk("reset out_valid", {8'h0, ov2}, 9'h0);
        chk("reset in_ready", {8'h0, rdy2}, 9'h1);
        chk("reset out_valid d4/d1", {7'h0, ov4, ov1}, 9'h0);

        // latency: one transaction, count edges until out_valid
        @(posedge clk); #1;
        a = 8'b1010; b = 8'b0111; cin = 1'b0; op = 1'b0;
        tbl_exp = 5'b1_0001; use_tbl = 1'b1; in_valid = 1'b1;
        cyc = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            in_valid = 1'b0;
            cyc++;
            if (ov2) break;
        end
        chk("latency cycles", 9'(cyc), 9'd2);
        drain(4);

        // table vectors back-to-back
        foreach (tbl[i]) send(tbl[i]);
        drain(6);

        // backpressure: 3 stalled cycles in the middle of 5 adds
        fork
            begin
                foreach (adds[i]) send(tbl[adds[i]]);
                in_valid = 1'b0;
            end
            begin
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b0;
                @(negedge clk);
                held = {c2, 4'h0, s2};
                chk("stall out_valid", {8'h0, ov2}, 9'h1);
                chk("stall in_ready", {8'h0, rdy2}, 9'h0);
                repeat (2) begin
                    @(negedge clk);
                    chk("stall hold", {c2, 4'h0, s2}, held);
                    chk("stall in_ready", {8'h0, rdy2}, 9'h0);
                end
                @(posedge clk); #1 out_ready = 1'b1;
            end
        join
        drain(8);
        chk("backpressure no loss", 9'(q2.size()), 9'd0);

        // reset with two transactions in flight
        send(tbl[0]);
        send(tbl[1]);
        in_valid = 1'b0; rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("post-reset out_valid", {8'h0, ov2}, 9'h0);
        repeat (5) begin
            @(negedge clk);
            chk("no stale result", {6'h0, ov2, ov4, ov1}, 9'h0);
        end

        // random operands, random valid and ready
        @(posedge clk); #1;
        use_tbl = 1'b0;
        for (int i = 0; i < 400; i++) begin
            a = 8'($urandom); b = 8'($urandom);
            cin = 1'($urandom); op = 1'($urandom);
            in_valid = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 4) != 0);
            @(posedge clk); #1;
        end
        drain(10);
        chk("drain d2", 9'(q2.size()), 9'd0);
        chk("drain d4", 9'(q4.size()), 9'd0);
        chk("drain d1", 9'(q1.size()), 9'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
